lms_adapt_ctrl: RTL and testbench

- Sequences adaptation of the fractionally-spaced equaliser's LMS engine in the receive chain (chfilt → aafilt → dwr2 → fse+lms → dwr1 → slicer).
- Clears the taps, waits for the pipeline to fill, then runs acquisition with a large step.
- Declares lock from windowed slicer-error energy, gear-shifts to a tracking step, and enables BER counting.
- Handles freeze, loss of lock and acquisition timeout with retry.

---
 rtl/lms_adapt_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_lms_adapt_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation sequencer for the fractionally-spaced equaliser.
// Clears the taps, waits for the pipeline to fill, then acquires with a large
// step. Lock is declared from windowed slicer-error energy. The block then
// shifts to a small tracking step and enables BER counting. It also handles
// freeze, loss of lock, and acquisition timeout with retry.
module lms_adapt_ctrl #(
    parameter int NBT_TAPS_ERR = 12,
    parameter int NBT_LMS_STEP = 12,
    parameter logic signed [NBT_LMS_STEP-1:0] STEP_ACQ = 12'sh008,
    parameter logic signed [NBT_LMS_STEP-1:0] STEP_TRK = 12'sh001,
    parameter int FILL_SYMS = 64,
    parameter int ACQ_SYMS  = 4096,
    parameter int WIN_LOG2  = 8,
    parameter logic [NBT_TAPS_ERR+WIN_LOG2:0] ERR_THR = 21'd8192,
    parameter int LOCK_WINS = 4,
    parameter int LOSS_WINS = 2
) (
    input  logic                             clk,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_freeze,
    input  logic                             i_sym_valid,
    input  logic [NBT_TAPS_ERR-1:0]          i_err_I,
    input  logic [NBT_TAPS_ERR-1:0]          i_err_Q,
    output logic                             o_taps_rst,
    output logic                             o_lms_en,
    output logic [NBT_LMS_STEP-1:0]          o_lms_step,
    output logic                             o_ber_en,
    output logic                             o_locked,
    output logic [2:0]                       o_state,
    output logic [NBT_TAPS_ERR+WIN_LOG2:0]   o_err_metric,
    output logic [7:0]                       o_retries
);

    localparam int ACC_W = NBT_TAPS_ERR + WIN_LOG2 + 1;
    localparam int ABS_W = NBT_TAPS_ERR - 1;
    localparam logic [WIN_LOG2-1:0] WIN_ONE = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        FILL   = 3'd2,
        ACQ    = 3'd3,
        TRACK  = 3'd4,
        FREEZE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [15:0]         sym_cnt_q;
    logic [16:0]         sym_cnt_p1;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sym_mag;
    logic [ACC_W-1:0]    win_sum;
    logic [7:0]          gc_q, bc_q, gc_next, bc_next;
    logic                monitoring, win_end, win_good;
    logic                fill_done, lock_hit, loss_hit, timeout_hit, acq_entry;

    logic                    taps_rst_d, lms_en_d, ber_en_d, locked_d;
    logic [NBT_LMS_STEP-1:0] lms_step_d;

    // Magnitude with the most negative code folded onto the largest positive one
    function automatic logic [ABS_W-1:0] sat_abs(input logic [NBT_TAPS_ERR-1:0] x);
        logic [NBT_TAPS_ERR-1:0] neg;
        neg = -x;
        if (!x[NBT_TAPS_ERR-1])
            sat_abs = x[ABS_W-1:0];
        else if (x[ABS_W-1:0] == '0)
            sat_abs = '1;
        else
            sat_abs = neg[ABS_W-1:0];
    endfunction

    assign sym_mag    = ACC_W'(sat_abs(i_err_I)) + ACC_W'(sat_abs(i_err_Q));
    assign win_sum    = acc_q + sym_mag;
    assign monitoring = (state_q == ACQ) || (state_q == TRACK) || (state_q == FREEZE);
    assign win_end    = i_sym_valid && monitoring && (win_cnt_q == '1);
    assign win_good   = (win_sum < ERR_THR);
    assign gc_next    = win_good ? ((gc_q == 8'hFF) ? gc_q : gc_q + 8'd1) : 8'd0;
    assign bc_next    = win_good ? 8'd0 : ((bc_q == 8'hFF) ? bc_q : bc_q + 8'd1);
    assign sym_cnt_p1 = {1'b0, sym_cnt_q} + 17'd1;

    assign fill_done   = (state_q == FILL) && i_sym_valid && (sym_cnt_p1 == 17'(FILL_SYMS));
    assign timeout_hit = (state_q == ACQ) && i_sym_valid && (sym_cnt_p1 == 17'(ACQ_SYMS));
    assign lock_hit    = (state_q == ACQ) && win_end && win_good &&
                         (int'(gc_q) + 1 >= LOCK_WINS);
    assign loss_hit    = ((state_q == TRACK) || (state_q == FREEZE)) && win_end && !win_good &&
                         (int'(bc_q) + 1 >= LOSS_WINS);
    assign acq_entry   = (state_d == ACQ) && (state_q != ACQ);

    // State register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; dropping the enable overrides everything else
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = CLR;
                CLR:    state_d = FILL;
                FILL:   if (fill_done) state_d = ACQ;
                ACQ: begin
                    if (lock_hit)
                        state_d = TRACK;
                    else if (timeout_hit)
                        state_d = CLR;
                end
                TRACK: begin
                    if (loss_hit)
                        state_d = ACQ;
                    else if (i_freeze)
                        state_d = FREEZE;
                end
                FREEZE: begin
                    if (loss_hit)
                        state_d = ACQ;
                    else if (!i_freeze)
                        state_d = TRACK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        taps_rst_d = (state_d == CLR);
        lms_en_d   = (state_d == ACQ) || (state_d == TRACK);
        locked_d   = (state_d == TRACK) || (state_d == FREEZE);
        ber_en_d   = locked_d;
        lms_step_d = '0;
        if (state_d == ACQ)
            lms_step_d = STEP_ACQ;
        else if (locked_d)
            lms_step_d = STEP_TRK;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_state    <= 3'd0;
            o_taps_rst <= 1'b0;
            o_lms_en   <= 1'b0;
            o_lms_step <= '0;
            o_locked   <= 1'b0;
            o_ber_en   <= 1'b0;
        end else begin
            o_state    <= state_d;
            o_taps_rst <= taps_rst_d;
            o_lms_en   <= lms_en_d;
            o_lms_step <= lms_step_d;
            o_locked   <= locked_d;
            o_ber_en   <= ber_en_d;
        end
    end

    // Strobe counters, window accumulator and good/bad window run lengths
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sym_cnt_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            gc_q      <= '0;
            bc_q      <= '0;
        end else if (!i_enable || state_q == IDLE || state_q == CLR || acq_entry) begin
            sym_cnt_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            gc_q      <= '0;
            bc_q      <= '0;
        end else if (i_sym_valid) begin
            case (state_q)
                FILL: sym_cnt_q <= sym_cnt_q + 16'd1;
                ACQ, TRACK, FREEZE: begin
                    if (state_q == ACQ)
                        sym_cnt_q <= sym_cnt_q + 16'd1;
                    win_cnt_q <= win_cnt_q + WIN_ONE;
                    if (win_end) begin
                        acc_q <= '0;
                        gc_q  <= gc_next;
                        bc_q  <= bc_next;
                    end else begin
                        acc_q <= win_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // Last window metric and saturating acquisition-retry count
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_err_metric <= '0;
            o_retries    <= '0;
        end else begin
            if (i_enable && win_end)
                o_err_metric <= win_sum;
            if (state_q == ACQ && state_d == CLR && o_retries != 8'hFF)
                o_retries <= o_retries + 8'd1;
        end
    end

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Self-checking bench for lms_adapt_ctrl: directed scenarios followed by
// randomized stimulus, all checked cycle by cycle against a behavioural model.
module tb_lms_adapt_ctrl;

    localparam int NBT_TAPS_ERR = 12;
    localparam int NBT_LMS_STEP = 12;
    localparam int FILL_SYMS    = 8;
    localparam int ACQ_SYMS     = 80;
    localparam int WIN_LOG2     = 4;
    localparam int WIN_LEN      = 1 << WIN_LOG2;
    localparam int ERR_THR_I    = 1024;
    localparam int LOCK_WINS    = 4;
    localparam int LOSS_WINS    = 2;
    localparam int MW           = NBT_TAPS_ERR + WIN_LOG2 + 1;

    logic                    clk = 1'b0;
    logic                    i_reset = 1'b0;
    logic                    i_enable = 1'b0;
    logic                    i_freeze = 1'b0;
    logic                    i_sym_valid = 1'b0;
    logic [NBT_TAPS_ERR-1:0] i_err_I = '0;
    logic [NBT_TAPS_ERR-1:0] i_err_Q = '0;
    logic                    o_taps_rst, o_lms_en, o_ber_en, o_locked;
    logic [NBT_LMS_STEP-1:0] o_lms_step;
    logic [2:0]              o_state;
    logic [MW-1:0]           o_err_metric;
    logic [7:0]              o_retries;

    lms_adapt_ctrl #(
        .NBT_TAPS_ERR(NBT_TAPS_ERR),
        .NBT_LMS_STEP(NBT_LMS_STEP),
        .STEP_ACQ(12'sh008),
        .STEP_TRK(12'sh001),
        .FILL_SYMS(FILL_SYMS),
        .ACQ_SYMS(ACQ_SYMS),
        .WIN_LOG2(WIN_LOG2),
        .ERR_THR(17'd1024),
        .LOCK_WINS(LOCK_WINS),
        .LOSS_WINS(LOSS_WINS)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_freeze(i_freeze),
        .i_sym_valid(i_sym_valid),
        .i_err_I(i_err_I),
        .i_err_Q(i_err_Q),
        .o_taps_rst(o_taps_rst),
        .o_lms_en(o_lms_en),
        .o_lms_step(o_lms_step),
        .o_ber_en(o_ber_en),
        .o_locked(o_locked),
        .o_state(o_state),
        .o_err_metric(o_err_metric),
        .o_retries(o_retries)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: state number plus strobe counts and the pending window
    int mState, mSym, mGc, mBc, mRetries, mMetric;
    int winQ[$];

    function automatic int satAbs(input int x);
        if (x < -2047) return 2047;
        if (x < 0) return -x;
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mSym = 0; mGc = 0; mBc = 0; mRetries = 0; mMetric = 0;
        winQ.delete();
    endtask

    task automatic modelAcqEntry();
        mSym = 0; mGc = 0; mBc = 0;
        winQ.delete();
    endtask

    task automatic modelEdge(input bit en, input bit frz, input bit sv, input int eI, input int eQ);
        bit winEnd;
        bit good;
        int s;
        winEnd = 0;
        good = 0;
        if (!en) begin
            mState = 0;
            modelAcqEntry();
            return;
        end
        case (mState)
            0: mState = 1;
            1: begin modelAcqEntry(); mState = 2; end
            2: if (sv) begin
                   mSym++;
                   if (mSym == FILL_SYMS) begin modelAcqEntry(); mState = 3; end
               end
            default: begin
                if (sv) begin
                    winQ.push_back(satAbs(eI) + satAbs(eQ));
                    if (mState == 3) mSym++;
                    if (winQ.size() == WIN_LEN) begin
                        s = 0;
                        foreach (winQ[k]) s += winQ[k];
                        mMetric = s;
                        winQ.delete();
                        winEnd = 1;
                        good = (s < ERR_THR_I);
                        if (good) begin mGc++; mBc = 0; end
                        else begin mGc = 0; mBc++; end
                    end
                end
                if (mState == 3) begin
                    if (winEnd && good && mGc >= LOCK_WINS) mState = 4;
                    else if (sv && mSym == ACQ_SYMS) begin
                        mState = 1;
                        if (mRetries < 255) mRetries++;
                    end
                end else if (mState == 4) begin
                    if (winEnd && mBc >= LOSS_WINS) begin modelAcqEntry(); mState = 3; end
                    else if (frz) mState = 5;
                end else begin
                    if (winEnd && mBc >= LOSS_WINS) begin modelAcqEntry(); mState = 3; end
                    else if (!frz) mState = 4;
                end
            end
        endcase
    endtask

    task automatic checkAll();
        bit lk;
        lk = (mState == 4) || (mState == 5);
        checkOutput("state", o_state, mState);
        checkOutput("tapsRst", o_taps_rst, (mState == 1) ? 1 : 0);
        checkOutput("lmsEn", o_lms_en, (mState == 3 || mState == 4) ? 1 : 0);
        checkOutput("lmsStep", o_lms_step, (mState == 3) ? 8 : (lk ? 1 : 0));
        checkOutput("locked", o_locked, lk ? 1 : 0);
        checkOutput("berEn", o_ber_en, lk ? 1 : 0);
        checkOutput("errMetric", o_err_metric, mMetric);
        checkOutput("retries", o_retries, mRetries);
    endtask

    task automatic applyStimulus(input bit en, input bit frz, input bit sv, input int eI, input int eQ);
        i_enable    = en;
        i_freeze    = frz;
        i_sym_valid = sv;
        i_err_I     = eI[NBT_TAPS_ERR-1:0];
        i_err_Q     = eQ[NBT_TAPS_ERR-1:0];
        @(posedge clk);
        if (i_reset) modelEdge(en, frz, sv, eI, eQ);
        else modelReset();
        #1;
        checkAll();
    endtask

    // Drive a constant error with a strobe every 'period' clocks until the
    // model reaches 'target'; an expired budget is reported as a failure.
    task automatic runUntil(input int target, input int budget, input bit frz,
                            input int period, input int e);
        int n;
        n = 0;
        while (mState != target && n < budget) begin
            applyStimulus(1'b1, frz, (n % period) == period - 1, e, e);
            n++;
        end
        checkOutput("reach", mState, target);
    endtask

    task automatic runCycles(input int cycles, input bit frz, input int period, input int e);
        for (int n = 0; n < cycles; n++)
            applyStimulus(1'b1, frz, (n % period) == period - 1, e, e);
    endtask

    initial begin
        int mode, e1, e2;
        bit en, frz, sv;
        modelReset();
        #12;
        checkAll();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        i_reset = 1'b1;

        // Acquisition with sparse strobes, lock into TRACK
        runUntil(4, 600, 1'b0, 4, 10);
        checkOutput("lockedInTrack", o_locked, 1);
        checkOutput("metricGood", o_err_metric, WIN_LEN * 20);

        // Large error in TRACK: loss after two bad windows
        runUntil(3, 100, 1'b0, 1, 100);
        checkOutput("lossUnlocked", o_locked, 0);
        checkOutput("metricBad", o_err_metric, WIN_LEN * 200);

        // Freeze / unfreeze, then loss while frozen
        runUntil(4, 200, 1'b0, 1, 5);
        runCycles(10, 1'b1, 1, 5);
        checkOutput("frozenState", o_state, 5);
        runCycles(5, 1'b0, 2, 5);
        runUntil(3, 100, 1'b1, 1, 100);

        // Most negative error saturates in the magnitude
        runCycles(40, 1'b0, 1, -2048);
        checkOutput("satMetric", o_err_metric, WIN_LEN * 4094);

        // Repeated timeouts drive the retry counter to saturation
        runCycles(27000, 1'b0, 1, 100);
        checkOutput("retriesSat", o_retries, 255);

        // Enable drop mid-ACQ keeps retries and metric
        runUntil(3, 200, 1'b0, 1, 100);
        runCycles(5, 1'b0, 1, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 100, 100);
        checkOutput("idleRetries", o_retries, 255);

        // Asynchronous reset in TRACK takes effect without a clock edge
        runUntil(4, 300, 1'b0, 1, 3);
        runCycles(10, 1'b0, 1, 3);
        #2;
        i_reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        i_reset = 1'b1;

        // Randomized traffic
        mode = 0;
        frz = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 40 == 0) mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) frz = ~frz;
            en = ($urandom_range(0, 299) != 0);
            sv = ($urandom_range(0, 2) != 0);
            case (mode)
                0: begin e1 = int'($urandom_range(0, 40)) - 20;  e2 = int'($urandom_range(0, 40)) - 20; end
                1: begin e1 = int'($urandom_range(0, 600)) - 300; e2 = int'($urandom_range(0, 600)) - 300; end
                2: begin e1 = int'($urandom_range(0, 80)) - 40;  e2 = int'($urandom_range(0, 80)) - 40; end
                default: begin
                    e1 = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
                    e2 = int'($urandom_range(0, 4095)) - 2048;
                end
            endcase
            applyStimulus(en, frz, sv, e1, e2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
